// File: rtl/simplez_loader.sv
// Serial program loader for the Simplez core: takes a framed image from the UART,
// writes it into RAM, holds the core in reset until the checksum verifies, answers 'K' or 'E'.
module simplez_loader #(
  parameter int unsigned TIMEOUT   = 12000000,
  parameter logic        BOOT_RUN  = 1'b1,
  parameter int unsigned MAX_WORDS = 504
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_req,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [11:0] mem_din,
  output logic        cpu_rstn,
  output logic        busy,
  output logic        err
);

  localparam int         TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] MAX_N   = 9'(MAX_WORDS);
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_E    = 8'h45;

  typedef enum logic [3:0] {
    OFF, IDLE, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, CHK, RESP
  } state_t;

  state_t        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          mem_we_q, mem_we_d;
  logic [8:0]    mem_addr_q, mem_addr_d;
  logic [11:0]   mem_din_q, mem_din_d;
  logic          cpu_rstn_q, cpu_rstn_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    chk_q, chk_d;
  logic [8:0]    wc_q, wc_d;
  logic [8:0]    n_q, n_d;
  logic          cnt_h0_q, cnt_h0_d;
  logic [3:0]    hi_q, hi_d;
  logic [7:0]    resp_q, resp_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic          timed;
  logic [8:0]    n_rx;
  logic [8:0]    wc_inc;

  // Handshakes: rx_rcv is a one-cycle strobe with no back-pressure (bytes arriving
  // in WRITE or RESP are dropped); tx_start pulses only in the cycle after tx_ready=1 was seen.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    cpu_rstn_d = cpu_rstn_q;
    busy_d     = busy_q;
    err_d      = err_q;
    chk_d      = chk_q;
    wc_d       = wc_q;
    n_d        = n_q;
    cnt_h0_d   = cnt_h0_q;
    hi_d       = hi_q;
    resp_d     = resp_q;
    timed      = state_q inside {CNT_H, CNT_L, DAT_H, DAT_L, CHK};
    n_rx       = {cnt_h0_q, rx_data};
    wc_inc     = wc_q + 9'd1;
    to_cnt_d   = '0;
    if (timed && !rx_rcv) to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      OFF: begin
        if (load_req) begin
          cpu_rstn_d = 1'b0;
          err_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      IDLE: begin
        if (rx_rcv && rx_data == CH_L) begin
          chk_d   = '0;
          wc_d    = '0;
          busy_d  = 1'b1;
          state_d = CNT_H;
        end
      end
      CNT_H: begin
        if (rx_rcv) begin
          cnt_h0_d = rx_data[0];
          state_d  = CNT_L;
        end
      end
      CNT_L: begin
        if (rx_rcv) begin
          if (n_rx == 9'd0 || n_rx > MAX_N) begin
            err_d   = 1'b1;
            resp_d  = CH_E;
            state_d = RESP;
          end else begin
            n_d        = n_rx;
            mem_addr_d = '0;
            state_d    = DAT_H;
          end
        end
      end
      DAT_H: begin
        if (rx_rcv) begin
          hi_d    = rx_data[3:0];
          chk_d   = chk_q + rx_data;
          state_d = DAT_L;
        end
      end
      DAT_L: begin
        if (rx_rcv) begin
          chk_d     = chk_q + rx_data;
          mem_din_d = {hi_q, rx_data};
          mem_we_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        wc_d = wc_inc;
        // The address holds on the final word so it never points past the image.
        if (wc_inc == n_q) begin
          state_d = CHK;
        end else begin
          mem_addr_d = mem_addr_q + 9'd1;
          state_d    = DAT_H;
        end
      end
      CHK: begin
        if (rx_rcv) begin
          if (rx_data == chk_q) begin
            resp_d = CH_K;
          end else begin
            resp_d = CH_E;
            err_d  = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (tx_start_q) begin
          if (resp_q == CH_K) begin
            cpu_rstn_d = 1'b1;
            state_d    = OFF;
          end else begin
            state_d = IDLE;
          end
        end else if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp_q;
          busy_d     = 1'b0;
        end
      end
      default: state_d = OFF;
    endcase

    if (timed && !rx_rcv && to_cnt_q == TO_LAST) begin
      err_d    = 1'b1;
      busy_d   = 1'b0;
      to_cnt_d = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= OFF;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_rstn_q <= BOOT_RUN;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      chk_q      <= '0;
      wc_q       <= '0;
      n_q        <= '0;
      cnt_h0_q   <= 1'b0;
      hi_q       <= '0;
      resp_q     <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      chk_q      <= chk_d;
      wc_q       <= wc_d;
      n_q        <= n_d;
      cnt_h0_q   <= cnt_h0_d;
      hi_q       <= hi_d;
      resp_q     <= resp_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign cpu_rstn = cpu_rstn_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_simplez_loader.sv
// Bench for simplez_loader: directed and randomized frames checked against a
// transaction-level model of RAM writes, response bytes, core reset and error flag.
`timescale 1ns/1ps
module tb_simplez_loader;

  localparam int unsigned TIMEOUT   = 60;
  localparam logic        BOOT_RUN  = 1'b1;
  localparam int unsigned MAX_WORDS = 504;
  localparam logic [7:0]  CH_L = 8'h4C;
  localparam logic [7:0]  CH_K = 8'h4B;
  localparam logic [7:0]  CH_E = 8'h45;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_req = 1'b0;
  logic        rx_rcv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [11:0] mem_din;
  logic        cpu_rstn;
  logic        busy;
  logic        err;

  simplez_loader #(
    .TIMEOUT  (TIMEOUT),
    .BOOT_RUN (BOOT_RUN),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .load_req(load_req),
    .rx_rcv  (rx_rcv),
    .rx_data (rx_data),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .cpu_rstn(cpu_rstn),
    .busy    (busy),
    .err     (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model state / scoreboard ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [20:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic        exp_cpu = BOOT_RUN;
  logic        exp_err = 1'b0;
  logic        model_off = 1'b1;
  logic        prev_tx_ready = 1'b1;
  logic [8:0]  last_wr_addr = 9'h000;
  logic [20:0] wr_e;
  logic [7:0]  tx_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      check("cpu_rstn", 32'(cpu_rstn), 32'(exp_cpu));
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexp_write: got addr %0h din %0h, required no write", mem_addr, mem_din);
        end else begin
          wr_e = exp_wr_q.pop_front();
          check("write", 32'({mem_addr, mem_din}), 32'(wr_e));
        end
        last_wr_addr = mem_addr;
      end
      if (tx_start) begin
        check("tx_after_ready", 32'(prev_tx_ready), 1);
        if (exp_tx_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexp_tx: got tx byte %0h, required no transmission", tx_data);
        end else begin
          tx_e = exp_tx_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(tx_e));
          if (tx_e == CH_K) begin
            exp_cpu   = 1'b1;
            model_off = 1'b1;
          end
        end
      end
    end
    prev_tx_ready = tx_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    cyc();
    rx_rcv  = 1'b1;
    rx_data = b;
    cyc();
    rx_rcv  = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic sendr(input logic [7:0] b);
    send_byte(b, $urandom_range(0, 5));
  endtask

  task automatic do_load();
    cyc();
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    if (model_off) begin
      exp_cpu   = 1'b0;
      exp_err   = 1'b0;
      model_off = 1'b0;
    end
  endtask

  task automatic wait_tx_drain(input string name);
    int t;
    t = 0;
    while (exp_tx_q.size() != 0 && t < 200) begin
      cyc();
      t++;
    end
    if (exp_tx_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_no_tx: got no response after %0d cycles, required %0d byte(s)", name, t, exp_tx_q.size());
      exp_tx_q.delete();
    end
    repeat (3) cyc();
    check({name, "_writes_owed"}, 32'(exp_wr_q.size()), 0);
    exp_wr_q.delete();
  endtask

  task automatic end_checks(input string name);
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_busy"}, 32'(busy), 0);
  endtask

  // Frame of n words (n is the 9-bit count field); model derives writes, checksum and reply.
  task automatic send_frame(input int n, input bit bad_chk, input bit mid_load, input bit hold_tx);
    logic [7:0] hi, lo, sum, ch, cnt_hb;
    cnt_hb = {7'($urandom_range(0, 127)), 1'(n >> 8)};
    sendr(CH_L);
    sendr(cnt_hb);
    if (n == 0 || n > int'(MAX_WORDS)) begin
      exp_tx_q.push_back(CH_E);
      exp_err = 1'b1;
      sendr(8'(n));
      wait_tx_drain("badcnt");
      end_checks("badcnt");
      return;
    end
    sendr(8'(n));
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      exp_wr_q.push_back({9'(i), hi[3:0], lo});
      sum = sum + hi + lo;
      sendr(hi);
      sendr(lo);
      if (mid_load && i == 0) begin
        cyc();
        load_req = 1'b1;
        cyc();
        load_req = 1'b0;
      end
    end
    ch = bad_chk ? sum + 8'($urandom_range(1, 255)) : sum;
    exp_tx_q.push_back(bad_chk ? CH_E : CH_K);
    if (bad_chk) exp_err = 1'b1;
    if (hold_tx) tx_ready = 1'b0;
    send_byte(ch, 0);
    if (hold_tx) begin
      repeat (20) cyc();
      check("tx_held", 32'(exp_tx_q.size()), 1);
      tx_ready = 1'b1;
    end
    wait_tx_drain("frame");
    end_checks("frame");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_din"}, 32'(mem_din), 0);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'(BOOT_RUN));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) cyc();
    check_reset_vals("por");
    rstn = 1'b1;
    cyc();

    // Directed good frame; checksum 0x0A+0x05+0x0E+0x00 = 0x1D.
    do_load();
    check("load_cpu_rstn", 32'(cpu_rstn), 0);
    exp_wr_q.push_back({9'h000, 12'hA05});
    exp_wr_q.push_back({9'h001, 12'hE00});
    exp_tx_q.push_back(8'h4B);
    sendr(8'h4C);
    check("busy_in_frame", 32'(busy), 1);
    sendr(8'h00); sendr(8'h02); sendr(8'h0A); sendr(8'h05); sendr(8'h0E); sendr(8'h00);
    send_byte(8'h1D, 0);
    wait_tx_drain("good");
    check("good_err", 32'(err), 0);
    check("good_cpu_rstn", 32'(cpu_rstn), 1);
    check("good_last_addr", 32'(last_wr_addr), 32'h001);

    // Directed bad checksum, then recovery without a new load_req.
    do_load();
    exp_wr_q.push_back({9'h000, 12'hA05});
    exp_wr_q.push_back({9'h001, 12'hE00});
    exp_tx_q.push_back(8'h45);
    exp_err = 1'b1;
    sendr(8'h4C); sendr(8'h00); sendr(8'h02); sendr(8'h0A); sendr(8'h05); sendr(8'h0E); sendr(8'h00);
    send_byte(8'h1E, 0);
    wait_tx_drain("badchk");
    check("badchk_err", 32'(err), 1);
    check("badchk_cpu_rstn", 32'(cpu_rstn), 0);
    send_frame(2, 1'b0, 1'b0, 1'b0);

    // Count bounds: 504 fills up to 0x1F7; 0 and 505 are rejected.
    do_load();
    send_frame(504, 1'b0, 1'b0, 1'b0);
    check("max_last_addr", 32'(last_wr_addr), 32'h1F7);
    check("max_err", 32'(err), 0);
    do_load();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    send_frame(505, 1'b0, 1'b0, 1'b0);
    send_frame(1, 1'b0, 1'b0, 1'b0);

    // Isolation: bytes while the core runs are ignored.
    sendr(8'h4C); sendr(8'h00); sendr(8'h01); sendr(8'h0A); sendr(8'h05); sendr(8'h0F);
    repeat (10) cyc();
    check("iso_busy", 32'(busy), 0);
    check("iso_cpu_rstn", 32'(cpu_rstn), 1);

    // load_req together with an 'L' byte: only the load is taken.
    cyc();
    load_req = 1'b1;
    rx_rcv   = 1'b1;
    rx_data  = CH_L;
    cyc();
    load_req = 1'b0;
    rx_rcv   = 1'b0;
    exp_cpu   = 1'b0;
    exp_err   = 1'b0;
    model_off = 1'b0;
    repeat (3) cyc();
    check("load_with_rx_busy", 32'(busy), 0);
    send_frame(3, 1'b0, 1'b1, 1'b1);

    // Timeout after a HI byte.
    do_load();
    sendr(8'h4C); sendr(8'h00); sendr(8'h01);
    send_byte(8'h0A, 0);
    repeat (TIMEOUT - 3) cyc();
    check("to_busy_before", 32'(busy), 1);
    check("to_err_before", 32'(err), 0);
    repeat (6) cyc();
    exp_err = 1'b1;
    check("to_busy_after", 32'(busy), 0);
    check("to_err_after", 32'(err), 1);
    send_frame(2, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    do_load();
    exp_wr_q.push_back({9'h000, 12'h3C5});
    sendr(8'h4C); sendr(8'h00); sendr(8'h03); sendr(8'hA3); sendr(8'hC5);
    send_byte(8'h17, 2);
    check("mid_writes_done", 32'(exp_wr_q.size()), 0);
    check("mid_busy", 32'(busy), 1);
    rstn = 1'b0;
    repeat (2) cyc();
    check_reset_vals("mid");
    exp_wr_q.delete();
    exp_tx_q.delete();
    exp_cpu   = BOOT_RUN;
    exp_err   = 1'b0;
    model_off = 1'b1;
    rstn = 1'b1;
    cyc();
    do_load();
    send_frame(4, 1'b0, 1'b0, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 10; k++) begin
      if (model_off) do_load();
      send_frame($urandom_range(1, 24), $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 3) == 0);
    end
    if (!model_off) send_frame(1, 1'b0, 1'b0, 1'b0);

    repeat (5) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
